// File: rtl/conv_tile_writeback.sv
// conv_tile_writeback
//
// Collects OT x OT convolution result tiles into full output strips, then
// streams each strip out as 8-bit pixels in raster order.
//
// Each tile element is quantized on the way in. The element is shifted
// right arithmetically by OUT_SHIFT and then clamped to 0..255. Two ping-pong
// banks each hold one strip of OT rows x OW pixels. While the reader drains
// one bank, the writer can fill the other bank.
//
// Handshake: a tile moves on every rising edge where i_tile_valid and
// o_tile_ready are both high. o_tile_ready is high exactly when the bank
// currently being written is not full. It is derived only from registered
// flags, so a bank released on an edge is seen as ready only in the
// following cycle.
//
// Ports:
//   clk                 clock; all state changes on the rising edge
//   reset               synchronous, active-high
//   i_tile_data         OT*OT signed RW-bit results; element (r,c) is at
//                       bits [(r*OT+c)*RW +: RW]
//   i_tile_valid        a tile is present on i_tile_data
//   o_tile_ready        the block can accept a tile this cycle
//   o_pixel_data        quantized output pixel; 0 when not valid
//   o_pixel_data_valid  o_pixel_data carries a pixel this cycle
//   o_frame_done        high together with the last pixel of a frame
module conv_tile_writeback #(
    parameter int KERNEL_SIZE       = 3,
    parameter int INPUT_IMAGE_WIDTH = 10,
    parameter int INPUT_TILE_SIZE   = 4,
    parameter int INPUT_DATA_WIDTH  = 8,
    parameter int KERNEL_DATA_WIDTH = 8,
    parameter int OUT_SHIFT         = 4,
    localparam int OT = INPUT_TILE_SIZE - KERNEL_SIZE + 1,
    localparam int RW = KERNEL_DATA_WIDTH + INPUT_DATA_WIDTH + 13
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [OT*OT*RW-1:0]   i_tile_data,
    input  logic                  i_tile_valid,
    output logic                  o_tile_ready,
    output logic [7:0]            o_pixel_data,
    output logic                  o_pixel_data_valid,
    output logic                  o_frame_done
);

    localparam int OW  = INPUT_IMAGE_WIDTH - KERNEL_SIZE + 1;
    localparam int TPR = OW / OT;
    localparam int SPF = OW / OT;
    localparam int TW  = (TPR > 1) ? $clog2(TPR) : 1;
    localparam int SW  = (SPF > 1) ? $clog2(SPF) : 1;
    localparam int RBW = (OT > 1) ? $clog2(OT) : 1;
    localparam int CW  = (OW > 1) ? $clog2(OW) : 1;

    localparam logic [TW-1:0]        TILE_LAST  = TW'(TPR - 1);
    localparam logic [SW-1:0]        STRIP_LAST = SW'(SPF - 1);
    localparam logic [RBW-1:0]       ROW_LAST   = RBW'(OT - 1);
    localparam logic [CW-1:0]        COL_LAST   = CW'(OW - 1);
    localparam logic signed [RW-1:0] SAT_MAX    = RW'(255);

    generate
        if (OW % OT != 0) begin : g_bad_geometry
            $error("conv_tile_writeback: output width must be a multiple of the output tile edge");
        end
    endgenerate

    typedef enum logic {IDLE, DRAIN} rd_state_t;

    logic [7:0]     mem [2][OT][OW];
    logic [1:0]     full;
    logic           wr_ptr;
    logic           rd_ptr;
    logic [TW-1:0]  tile_cnt;
    logic [RBW-1:0] rd_row;
    logic [CW-1:0]  rd_col;
    logic [SW-1:0]  strip_cnt;
    rd_state_t      rd_state;
    logic           accept;
    logic           emit;
    logic           last_pix;

    function automatic logic [7:0] quantize(input logic signed [RW-1:0] x);
        logic signed [RW-1:0] y;
        y = x >>> OUT_SHIFT;
        if (y[RW-1])          return 8'd0;
        else if (y > SAT_MAX) return 8'hFF;
        else                  return y[7:0];
    endfunction

    assign o_tile_ready = !full[wr_ptr];
    assign accept       = i_tile_valid && o_tile_ready;
    // In IDLE the row and column counters are at 0. A full read bank
    // therefore emits pixel (0,0) on the same edge that enters DRAIN,
    // which gives the one-edge start-up latency.
    assign emit         = (rd_state == DRAIN) || full[rd_ptr];
    assign last_pix     = (rd_row == ROW_LAST) && (rd_col == COL_LAST);

    // Bank storage holds no reset value; the full flags decide what is live.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int r = 0; r < OT; r++) begin
                for (int c = 0; c < OT; c++) begin
                    mem[wr_ptr][r][CW'(int'(tile_cnt) * OT + c)] <=
                        quantize(i_tile_data[(r*OT+c)*RW +: RW]);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            full               <= '0;
            wr_ptr             <= 1'b0;
            rd_ptr             <= 1'b0;
            tile_cnt           <= '0;
            rd_row             <= '0;
            rd_col             <= '0;
            strip_cnt          <= '0;
            rd_state           <= IDLE;
            o_pixel_data       <= 8'd0;
            o_pixel_data_valid <= 1'b0;
            o_frame_done       <= 1'b0;
        end else begin
            o_frame_done <= 1'b0;

            // Writer side. It only ever sets the flag of a non-full bank.
            // The reader only clears the flag of a full bank, so the two
            // sides never touch the same flag on the same edge.
            if (accept) begin
                if (tile_cnt == TILE_LAST) begin
                    full[wr_ptr] <= 1'b1;
                    wr_ptr       <= ~wr_ptr;
                    tile_cnt     <= '0;
                end else begin
                    tile_cnt <= tile_cnt + 1'b1;
                end
            end

            // Reader side.
            if (emit) begin
                o_pixel_data       <= mem[rd_ptr][rd_row][rd_col];
                o_pixel_data_valid <= 1'b1;
                rd_state           <= DRAIN;
                if (last_pix) begin
                    full[rd_ptr] <= 1'b0;
                    rd_ptr       <= ~rd_ptr;
                    rd_row       <= '0;
                    rd_col       <= '0;
                    if (strip_cnt == STRIP_LAST) begin
                        o_frame_done <= 1'b1;
                        strip_cnt    <= '0;
                    end else begin
                        strip_cnt <= strip_cnt + 1'b1;
                    end
                    // If the other bank is already waiting, stay in DRAIN so
                    // that its first pixel follows without a gap.
                    if (!full[~rd_ptr]) rd_state <= IDLE;
                end else if (rd_col == COL_LAST) begin
                    rd_col <= '0;
                    rd_row <= rd_row + 1'b1;
                end else begin
                    rd_col <= rd_col + 1'b1;
                end
            end else begin
                o_pixel_data       <= 8'd0;
                o_pixel_data_valid <= 1'b0;
                rd_state           <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_conv_tile_writeback.sv
// Bench for conv_tile_writeback. The reference model keeps whole strips as
// 2-D pixel arrays and an expected-pixel queue. It quantizes with floor
// division, and it tracks how many completed strips are still waiting to be
// streamed out.
module tb_conv_tile_writeback;

    localparam int KS   = 3;
    localparam int IW   = 10;
    localparam int ITS  = 4;
    localparam int IDW  = 8;
    localparam int KDW  = 8;
    localparam int SH   = 4;
    localparam int OT   = ITS - KS + 1;
    localparam int RW   = KDW + IDW + 13;
    localparam int OW   = IW - KS + 1;
    localparam int TPR  = OW / OT;
    localparam int SPF  = OW / OT;
    localparam int SPIX = OT * OW;
    localparam int FPIX = SPIX * SPF;
    localparam int TB   = OT * OT * RW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [TB-1:0] i_tile_data = '0;
    logic          i_tile_valid = 1'b0;
    logic          o_tile_ready;
    logic [7:0]    o_pixel_data;
    logic          o_pixel_data_valid;
    logic          o_frame_done;

    conv_tile_writeback #(
        .KERNEL_SIZE(KS), .INPUT_IMAGE_WIDTH(IW), .INPUT_TILE_SIZE(ITS),
        .INPUT_DATA_WIDTH(IDW), .KERNEL_DATA_WIDTH(KDW), .OUT_SHIFT(SH)
    ) dut (
        .clk(clk), .reset(reset), .i_tile_data(i_tile_data),
        .i_tile_valid(i_tile_valid), .o_tile_ready(o_tile_ready),
        .o_pixel_data(o_pixel_data), .o_pixel_data_valid(o_pixel_data_valid),
        .o_frame_done(o_frame_done)
    );

    // clock / reset block
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // checking
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // reference model
    logic [7:0]    exp_q[$];
    logic [7:0]    strip_img [OT][OW];
    int            m_tile = 0;
    int            occupied = 0;
    int            pix_total = 0;
    int            strip_pix = 0;
    bit            pend = 0;
    logic [TB-1:0] pend_data = '0;
    bit            exp_valid_next = 0;

    function automatic logic [7:0] ref_quant(input longint x);
        longint d, y;
        d = longint'(1) << SH;
        if (x >= 0) y = x / d;
        else        y = -((-x + d - 1) / d);   // floor for negatives
        if (y < 0)   return 8'd0;
        if (y > 255) return 8'd255;
        return 8'(y);
    endfunction

    task automatic model_take_tile(input logic [TB-1:0] d);
        logic signed [RW-1:0] e;
        for (int r = 0; r < OT; r++)
            for (int c = 0; c < OT; c++) begin
                e = d[(r*OT+c)*RW +: RW];
                strip_img[r][m_tile*OT + c] = ref_quant(longint'(e));
            end
        m_tile++;
        if (m_tile == TPR) begin
            m_tile = 0;
            occupied++;
            for (int r = 0; r < OT; r++)
                for (int c = 0; c < OW; c++) exp_q.push_back(strip_img[r][c]);
        end
    endtask

    // Scoreboard: sample on the falling edge. The outputs reflect the last
    // rising edge, and the inputs are stable until the next one.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            m_tile = 0; occupied = 0; pix_total = 0; strip_pix = 0;
            pend = 0; exp_valid_next = 0;
        end else begin
            check_val("pix_valid", o_pixel_data_valid, exp_valid_next);
            if (o_pixel_data_valid) begin
                if (exp_q.size() > 0) check_val("pixel", o_pixel_data, exp_q.pop_front());
                check_val("frame_done", o_frame_done, (pix_total % FPIX) == FPIX - 1);
                pix_total++;
                strip_pix++;
                if (strip_pix == SPIX) begin
                    strip_pix = 0;
                    if (occupied > 0) occupied--;
                end
            end else begin
                check_val("idle_data", o_pixel_data, 0);
                check_val("idle_fd", o_frame_done, 0);
            end
            if (pend) model_take_tile(pend_data);
            check_val("tile_ready", o_tile_ready, occupied < 2);
            pend = i_tile_valid && o_tile_ready;
            pend_data = i_tile_data;
            exp_valid_next = (exp_q.size() > 0);
        end
    end

    // driver tasks (callers are always just after a rising edge)
    task automatic do_reset(input int n);
        reset = 1'b1;
        i_tile_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_val("rst_valid", o_pixel_data_valid, 0);
        check_val("rst_data", o_pixel_data, 0);
        check_val("rst_fd", o_frame_done, 0);
        check_val("rst_ready", o_tile_ready, 1);
        @(posedge clk); #1;
    endtask

    // Presents a tile and returns just after the edge that took it.
    // i_tile_valid is left high so that consecutive calls stream back to back.
    task automatic send_tile(input logic [TB-1:0] d);
        int w;
        i_tile_data = d;
        i_tile_valid = 1'b1;
        w = 0;
        @(negedge clk);
        while (!o_tile_ready && w < 400) begin
            w++;
            @(negedge clk);
        end
        check_val("send_bound", w >= 400, 0);
        @(posedge clk); #1;
    endtask

    task automatic idle_cycles(input int n);
        i_tile_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int w;
        i_tile_valid = 1'b0;
        w = 0;
        while ((exp_q.size() != 0 || occupied != 0 || pend) && w < 2000) begin
            @(posedge clk); #1;
            w++;
        end
        check_val("drain_bound", w >= 2000, 0);
        idle_cycles(3);
    endtask

    function automatic logic [TB-1:0] pattern_tile(input int t);
        logic [TB-1:0] d;
        int v;
        d = '0;
        for (int r = 0; r < OT; r++)
            for (int c = 0; c < OT; c++) begin
                v = (r*8 + t*2 + c) << 4;
                d[(r*OT+c)*RW +: RW] = v[RW-1:0];
            end
        return d;
    endfunction

    function automatic logic [TB-1:0] rand_tile();
        logic [TB-1:0] d;
        int v;
        d = '0;
        for (int i = 0; i < OT*OT; i++) begin
            case ($urandom_range(0, 3))
                0: v = int'($urandom_range(0, 4095));
                1: v = -int'($urandom_range(0, 2000));
                2: v = int'($urandom_range(4000, 8000));
                default: v = int'($urandom);
            endcase
            d[i*RW +: RW] = v[RW-1:0];
        end
        return d;
    endfunction

    function automatic logic [TB-1:0] elems_tile(input int e0, input int e1, input int e2, input int e3);
        logic [TB-1:0] d;
        int v[4];
        v[0] = e0; v[1] = e1; v[2] = e2; v[3] = e3;
        d = '0;
        for (int i = 0; i < 4; i++) d[i*RW +: RW] = v[i][RW-1:0];
        return d;
    endfunction

    initial begin
        int w;

        // reset held for two cycles
        do_reset(2);

        // ordering: pixel values 0..15 in raster order
        for (int t = 0; t < TPR; t++) send_tile(pattern_tile(t));
        wait_drain();

        // clamp boundaries
        send_tile(elems_tile(-5, 16, 31, 4095));
        send_tile(elems_tile(4096, -1, 15, 4079));
        send_tile(elems_tile(-268435456, 268435455, 255 << 4, 256 << 4));
        send_tile(rand_tile());
        wait_drain();

        // random strips with random idle gaps
        for (int i = 0; i < 2*TPR; i++) begin
            send_tile(rand_tile());
            idle_cycles($urandom_range(0, 3));
        end
        wait_drain();

        // backpressure: 12 tiles offered back to back
        for (int i = 0; i < 3*TPR; i++) send_tile(rand_tile());
        wait_drain();

        // full frame, then the first strip of the next frame
        do_reset(2);
        for (int i = 0; i < TPR*SPF + TPR; i++) send_tile(rand_tile());
        wait_drain();

        // reset mid-drain, then a fresh strip
        for (int t = 0; t < TPR; t++) send_tile(rand_tile());
        i_tile_valid = 1'b0;
        w = 0;
        while (strip_pix < 5 && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
        check_val("middrain_bound", w >= 200, 0);
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check_val("middrain_valid", o_pixel_data_valid, 0);
        check_val("middrain_ready", o_tile_ready, 1);
        @(posedge clk); #1;
        for (int t = 0; t < TPR; t++) send_tile(pattern_tile(t));
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
